// File: rtl/term_text_engine.sv
// -----------------------------------------------------------------------------
// term_text_engine
//
// Character-screen engine that sits between a UART receiver and a VGA text
// renderer. Received bytes are buffered in a small FIFO and then decoded, one
// byte at a time, into a COLS x ROWS character RAM. The engine tracks a cursor
// and scrolls by rotating a circular row base rather than moving RAM contents.
// A separate registered read port serves the display side, addressed in
// logical (on-screen) rows.
//
// Optional build macro:
//   TERM_FORMFEED_CLEAR_EN - when defined, byte 0x0C (FF) homes the cursor,
//                            resets the row base and clears the whole screen.
//                            When undefined, 0x0C is ignored.
//
// Ports:
//   clk         in   system clock; all logic is rising-edge
//   rst_n       in   asynchronous active-low reset
//   rx_data     in   received byte
//   rx_valid    in   one-cycle strobe qualifying rx_data
//   clr_ovf     in   clears the ovf flag
//   rd_col      in   display read column
//   rd_row      in   display read logical row (0 = top of screen)
//   rd_char     out  character at (rd_row, rd_col), one cycle later
//   cur_col     out  cursor column
//   cur_row     out  cursor logical row
//   scroll_base out  physical RAM row displayed as logical row 0
//   busy        out  high while the engine is clearing the screen or a line
//   ovf         out  sticky: a byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module term_text_engine #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 4,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clr_ovf,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_char,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] cur_row,
  output logic [ROW_W-1:0] scroll_base,
  output logic             busy,
  output logic             ovf
);

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [7:0]        SPACE     = 8'h20;
  localparam logic [7:0]        CH_BS     = 8'h08;
  localparam logic [7:0]        CH_LF     = 8'h0A;
  localparam logic [7:0]        CH_CR     = 8'h0D;
`ifdef TERM_FORMFEED_CLEAR_EN
  localparam logic [7:0]        CH_FF     = 8'h0C;
`endif
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CELLS - 1);
  localparam logic [ROW_W:0]    ROWS_X    = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0]    COLS_X    = (COL_W + 1)'(COLS);

  typedef enum logic [1:0] {CLR_ALL, IDLE, EXEC, CLR_LINE} state_t;

  // (a + b) mod ROWS for a, b < ROWS: one compare-subtract, no divider.
  function automatic logic [ROW_W-1:0] row_wrap(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= ROWS_X) sum = sum - ROWS_X;
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  state_t            state;
  logic [7:0]        mem [CELLS];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, pop;
  logic [7:0]        exec_byte;
  logic [ADDR_W-1:0] clr_addr;
  logic [COL_W-1:0]  clr_col;
  logic [ROW_W-1:0]  clr_row;
  logic [ROW_W-1:0]  cur_phys, rd_phys;
  logic              is_print, nl_req, rd_oob;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Input FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push       = rx_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // A drop in the same cycle as clr_ovf wins, so no drop goes unreported.
      if (rx_valid && fifo_full) ovf <= 1'b1;
      else if (clr_ovf)          ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_data;
    if (pop)  exec_byte <= fifo_mem[rd_ptr[PTR_W-1:0]];
  end

  // Decode of the byte held for EXEC.
  assign cur_phys = row_wrap(cur_row, scroll_base);
  assign is_print = (exec_byte >= 8'h20) && (exec_byte <= 8'h7E);
  assign nl_req   = (state == EXEC) &&
                    ((is_print && (cur_col == COL_LAST)) || (exec_byte == CH_LF));

  // Single RAM write port shared by the clear sequencers and EXEC.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = SPACE;
    case (state)
      CLR_ALL:  wr_en = 1'b1;
      CLR_LINE: begin
        wr_en   = 1'b1;
        wr_addr = cell_addr(clr_row, clr_col);
      end
      EXEC: begin
        if (is_print) begin
          wr_en   = 1'b1;
          wr_addr = cell_addr(cur_phys, cur_col);
          wr_data = exec_byte;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLR_ALL;
      busy        <= 1'b1;
      clr_addr    <= '0;
      clr_col     <= '0;
      clr_row     <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      scroll_base <= '0;
      rd_ptr      <= '0;
    end else begin
      case (state)
        CLR_ALL: begin
          if (clr_addr == ADDR_LAST) begin
            clr_addr <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end

        IDLE: begin
          if (!fifo_empty) begin
            rd_ptr <= rd_ptr + 1'b1;
            state  <= EXEC;
          end
        end

        EXEC: begin
          state <= IDLE;
          if (is_print) begin
            cur_col <= (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
          end else if (exec_byte == CH_CR) begin
            cur_col <= '0;
          end else if (exec_byte == CH_BS) begin
            if (cur_col != '0) cur_col <= cur_col - 1'b1;
          end
`ifdef TERM_FORMFEED_CLEAR_EN
          else if (exec_byte == CH_FF) begin
            cur_col     <= '0;
            cur_row     <= '0;
            scroll_base <= '0;
            clr_addr    <= '0;
            busy        <= 1'b1;
            state       <= CLR_ALL;
          end
`endif
          if (nl_req) begin
            if (cur_row != ROW_LAST) begin
              cur_row <= cur_row + 1'b1;
            end else begin
              // The row that falls off the top becomes the new bottom line,
              // i.e. the old base row is the one to blank.
              scroll_base <= row_wrap(scroll_base, ROW_W'(1));
              clr_row     <= scroll_base;
              clr_col     <= '0;
              busy        <= 1'b1;
              state       <= CLR_LINE;
            end
          end
        end

        CLR_LINE: begin
          if (clr_col == COL_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            clr_col <= clr_col + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Display read port: logical row -> physical row, one register stage.
  assign rd_phys = row_wrap(rd_row, scroll_base);
  assign rd_oob  = ({1'b0, rd_row} >= ROWS_X) || ({1'b0, rd_col} >= COLS_X);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_char <= SPACE;
    else        rd_char <= rd_oob ? SPACE : mem[cell_addr(rd_phys, rd_col)];
  end

endmodule

// File: tb/tb_term_text_engine.sv
module tb_term_text_engine;

  localparam int COLS       = 4;
  localparam int ROWS       = 3;
  localparam int FIFO_DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       clr_ovf  = 1'b0;
  logic [1:0] rd_col   = 2'd0;
  logic [1:0] rd_row   = 2'd0;
  logic [7:0] rd_char;
  logic [1:0] cur_col, cur_row, scroll_base;
  logic       busy, ovf;

  int checks = 0;
  int errors = 0;

  term_text_engine #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clr_ovf(clr_ovf), .rd_col(rd_col), .rd_row(rd_row), .rd_char(rd_char),
    .cur_col(cur_col), .cur_row(cur_row), .scroll_base(scroll_base),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    repeat (3) tick();
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    tick();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic send_drain(input logic [7:0] b);
    send(b);
    drain("send");
  endtask

  task automatic busy_len(output int n);
    int k;
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic read_cell(input int row, input int col, output logic [7:0] v);
    rd_row = 2'(row);
    rd_col = 2'(col);
    tick();
    v = rd_char;
  endtask

  task automatic check_row(input int row, input string exp4);
    logic [7:0] v;
    for (int c = 0; c < COLS; c++) begin
      read_cell(row, c, v);
      check($sformatf("row%0d_col%0d", row, c), {24'd0, v}, {24'd0, exp4[c]});
    end
  endtask

  task automatic check_cursor(input string tag, input int row, input int col, input int base);
    check({tag, "_cur_row"}, {30'd0, cur_row}, 32'(row));
    check({tag, "_cur_col"}, {30'd0, cur_col}, 32'(col));
    check({tag, "_base"}, {30'd0, scroll_base}, 32'(base));
  endtask

  task automatic do_reset(input string tag);
    int n;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) tick();
    check({tag, "_rd_char"}, {24'd0, rd_char}, 32'h20);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    rst_n = 1'b1;
    busy_len(n);
    check({tag, "_busy_len"}, 32'(n), 32'd12);
  endtask

  initial begin
    int n;
    logic [7:0] v;
    string s;

    // Reset and full-screen clear
    do_reset("rst1");
    check_cursor("rst1", 0, 0, 0);
    check("rst1_ovf", {31'd0, ovf}, 32'd0);
    for (int r = 0; r < ROWS; r++) check_row(r, "    ");
    read_cell(3, 0, v);
    check("oob_row", {24'd0, v}, 32'h20);

    // Printable bytes with column wrap
    s = "ABCDE";
    for (int i = 0; i < 5; i++) send_drain(s[i]);
    check_row(0, "ABCD");
    read_cell(1, 0, v);
    check("wrap_E", {24'd0, v}, 32'h45);
    check_cursor("abcde", 1, 1, 0);

    // Fill the screen; the last character scrolls
    do_reset("rst2");
    s = "AAAABBBBCCC";
    for (int i = 0; i < 11; i++) send_drain(s[i]);
    check_cursor("fill", 2, 3, 0);
    send("C");
    busy_len(n);
    check("scroll1_busy_len", 32'(n), 32'd4);
    drain("scroll1");
    check_cursor("scroll1", 2, 0, 1);
    check_row(0, "BBBB");
    check_row(1, "CCCC");
    check_row(2, "    ");

    // LF on the bottom row scrolls again; logical row read wraps
    send(8'h0A);
    busy_len(n);
    check("scroll2_busy_len", 32'(n), 32'd4);
    drain("scroll2");
    check_cursor("scroll2", 2, 0, 2);
    check_row(0, "CCCC");
    check_row(1, "    ");
    check_row(2, "    ");

    // Backspace and carriage return
    send_drain("X");
    check("x_col", {30'd0, cur_col}, 32'd1);
    send_drain(8'h08);
    check("bs1_col", {30'd0, cur_col}, 32'd0);
    send_drain(8'h08);
    check("bs2_col", {30'd0, cur_col}, 32'd0);
    send_drain("Y");
    check_cursor("y", 2, 1, 2);
    check_row(2, "Y   ");
    send_drain(8'h0D);
    check("cr_col", {30'd0, cur_col}, 32'd0);

    // Overflow: LF starts a line clear, six bytes follow back-to-back
    send(8'h0A);
    s = "pqr";
    for (int i = 0; i < 3; i++) send(s[i]);
    send(8'h0D);
    send("s");
    send("t");
    check("ovf_set", {31'd0, ovf}, 32'd1);
    repeat (12) tick();
    drain("ovf");
    check_cursor("ovf", 2, 0, 0);
    check_row(0, "    ");
    check_row(1, "Y   ");
    check_row(2, "pqr ");
    check("ovf_sticky", {31'd0, ovf}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr", {31'd0, ovf}, 32'd0);

    // Scroll once more, then form feed
    send(8'h0A);
    busy_len(n);
    check("scroll3_busy_len", 32'(n), 32'd4);
    drain("scroll3");
    check_cursor("scroll3", 2, 0, 1);
    check_row(0, "Y   ");
    check_row(1, "pqr ");
    send(8'h0C);
`ifdef TERM_FORMFEED_CLEAR_EN
    busy_len(n);
    check("ff_busy_len", 32'(n), 32'd12);
    drain("ff");
    check_cursor("ff", 0, 0, 0);
    for (int r = 0; r < ROWS; r++) check_row(r, "    ");
`else
    drain("ff");
    check_cursor("ff_ignored", 2, 0, 1);
    check_row(0, "Y   ");
    check_row(1, "pqr ");
    check_row(2, "    ");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
